serial_tx_device: RTL and testbench

//  Memory-mapped serial transmitter on the CPU data bus; the output-direction counterpart of the key input device.
//  CPU writes a byte to the data address; block frames it (1 start, 8 data LSB-first, 1 stop) on txd.

---
 rtl/serial_tx_pkg.sv | 25 ++
 rtl/serial_tx_shifter.sv | 123 ++++++++++++
 rtl/serial_tx_device.sv | 155 +++++++++++++++
 tb/tb_serial_tx_device.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the memory-mapped serial transmitter.
// Contents: FSM state enum, control register bit positions, frame length helper.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam int unsigned CTRL_READY   = 0;
  localparam int unsigned CTRL_BUSY    = 1;
  localparam int unsigned CTRL_OVR     = 2;
  localparam int unsigned CTRL_OCC_LSB = 4;
  localparam int unsigned CTRL_OCC_W   = 4;
  localparam int unsigned CTRL_IE      = 8;

  // Clock cycles for one complete frame (start + data + stop bits).
  function automatic int unsigned frameLen(input int unsigned dataWidth,
                                           input int unsigned clkDiv);
    return (dataWidth + 2) * clkDiv;
  endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// Serial framing engine: baud counter, shift register and line driver.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   load           a byte is waiting on the bus side
//   loadData       the waiting byte
//   loadAck_c      byte taken this cycle (combinational pulse)
//   active_c       FSM is not IDLE
//   txd            registered serial line, idle high
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadData,
  output logic                  loadAck_c,
  output logic                  active_c,
  output logic                  txd
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  txState_t              state, stateNext;
  logic [CNT_W-1:0]      baudCnt, cntNext;
  logic [BIT_W-1:0]      bitIdx, bitNext;
  logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
  logic                  txdNext;
  logic                  baudEnd;

  assign baudEnd  = (baudCnt == CNT_LAST);
  assign active_c = (state != IDLE);

  // State register; txd is computed one cycle ahead so the line is a flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txd      <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= cntNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      txd      <= txdNext;
    end
  end

  // Next-state, next-line-level and handshake decode.
  always_comb begin
    stateNext = state;
    cntNext   = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txdNext   = txd;
    loadAck_c = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          stateNext = START;
          shiftNext = loadData;
          txdNext   = 1'b0;
          cntNext   = '0;
          loadAck_c = 1'b1;
        end
      end
      START: begin
        if (baudEnd) begin
          stateNext = DATA;
          txdNext   = shiftReg[0];
          bitNext   = '0;
          cntNext   = '0;
        end else begin
          cntNext = baudCnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baudEnd) begin
          cntNext = '0;
          if (bitIdx == BIT_LAST) begin
            stateNext = STOP;
            txdNext   = 1'b1;
          end else begin
            shiftNext = shiftReg >> 1;
            txdNext   = shiftReg[1];
            bitNext   = bitIdx + BIT_W'(1);
          end
        end else begin
          cntNext = baudCnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baudEnd) begin
          cntNext = '0;
          // A waiting byte starts the next frame with no idle gap.
          if (load) begin
            stateNext = START;
            shiftNext = loadData;
            txdNext   = 1'b0;
            loadAck_c = 1'b1;
          end else begin
            stateNext = IDLE;
            txdNext   = 1'b1;
          end
        end else begin
          cntNext = baudCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        txdNext   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/serial_tx_device.sv
// Memory-mapped serial transmitter: bus decode, holding register (or FIFO),
// control register, read mux and interrupt request.
// Optional build macro: SERIAL_TX_FIFO_EN replaces the single holding register
// with a FIFO_DEPTH-entry FIFO and exposes its occupancy in ctrl[7:4].
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   we, re         bus write / read strobes
//   memAddr        bus address
//   dataBusIn      write data
//   dataBusOut     read data, 0 when the block is not being read
//   txd            serial line, idle high
//   intr           interrupt request = IE & ready
module serial_tx_device
  import serial_tx_pkg::*;
#(
  parameter int unsigned     BITS       = 32,
  parameter int unsigned     DATA_WIDTH = 8,
  parameter logic [BITS-1:0] BASE       = 32'hF0000010,
  parameter logic [BITS-1:0] CTRL_BASE  = 32'hF0000110,
  parameter int unsigned     CLK_DIV    = 16,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic            re,
  input  logic [BITS-1:0] memAddr,
  input  logic [BITS-1:0] dataBusIn,
  output logic [BITS-1:0] dataBusOut,
  output logic            txd,
  output logic            intr
);

  logic                  dataSel, ctrlSel, dataWr, ctrlWr, rdEn;
  logic                  ready, readyNext, pending, busy;
  logic                  push, loadAck_c, shiftActive_c;
  logic [DATA_WIDTH-1:0] headData, lastByte;
  logic [CTRL_OCC_W-1:0] occField;
  logic                  overrun, ovrNext, ie, ieNext;
  logic [BITS-1:0]       ctrlWord;
  logic                  unusedBits;

  assign dataSel    = (memAddr == BASE);
  assign ctrlSel    = (memAddr == CTRL_BASE);
  assign dataWr     = we & dataSel;
  assign ctrlWr     = we & ctrlSel;
  assign rdEn       = re & ~we;
  assign push       = dataWr & ready;
  assign busy       = shiftActive_c | pending;
  assign unusedBits = ^dataBusIn;

`ifdef SERIAL_TX_FIFO_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [OCC_W-1:0]      occ, occNext;

  assign ready     = (occ != OCC_FULL);
  assign pending   = (occ != '0);
  assign headData  = fifoMem[rdPtr];
  assign occNext   = occ + OCC_W'(push) - OCC_W'(loadAck_c);
  assign readyNext = (occNext != OCC_FULL);
  assign occField  = CTRL_OCC_W'(occ);

  // FIFO storage carries no reset; validity is tracked by occ.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= dataBusIn[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      occ   <= '0;
    end else begin
      if (push)      wrPtr <= wrPtr + PTR_W'(1);
      if (loadAck_c) rdPtr <= rdPtr + PTR_W'(1);
      occ <= occNext;
    end
  end
`else
  logic holdFull, holdFullNext;
  logic [DATA_WIDTH-1:0] holdData;

  assign ready        = ~holdFull;
  assign pending      = holdFull;
  assign headData     = holdData;
  assign holdFullNext = push | (holdFull & ~loadAck_c);
  assign readyNext    = ~holdFullNext;
  assign occField     = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      holdFull <= 1'b0;
      holdData <= '0;
    end else begin
      holdFull <= holdFullNext;
      if (push) holdData <= dataBusIn[DATA_WIDTH-1:0];
    end
  end
`endif

  // Overrun is sticky: a rejected write beats a simultaneous write-0 clear.
  always_comb begin
    ovrNext = overrun;
    if (dataWr & ~ready)                     ovrNext = 1'b1;
    else if (ctrlWr & ~dataBusIn[CTRL_OVR])  ovrNext = 1'b0;
    ieNext = ctrlWr ? dataBusIn[CTRL_IE] : ie;
  end

  // intr is registered from next-state values so it tracks IE & ready without lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      ie       <= 1'b0;
      intr     <= 1'b0;
      lastByte <= '0;
    end else begin
      overrun <= ovrNext;
      ie      <= ieNext;
      intr    <= ieNext & readyNext;
      if (push) lastByte <= dataBusIn[DATA_WIDTH-1:0];
    end
  end

  // Control word and read mux.
  always_comb begin
    ctrlWord                                = '0;
    ctrlWord[CTRL_READY]                    = ready;
    ctrlWord[CTRL_BUSY]                     = busy;
    ctrlWord[CTRL_OVR]                      = overrun;
    ctrlWord[CTRL_OCC_LSB +: CTRL_OCC_W]    = occField;
    ctrlWord[CTRL_IE]                       = ie;
    dataBusOut = '0;
    if (rdEn & dataSel)      dataBusOut = BITS'(lastByte);
    else if (rdEn & ctrlSel) dataBusOut = ctrlWord;
  end

  serial_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLK_DIV   (CLK_DIV)
  ) uShifter (
    .clk      (clk),
    .reset    (reset),
    .load     (pending),
    .loadData (headData),
    .loadAck_c(loadAck_c),
    .active_c (shiftActive_c),
    .txd      (txd)
  );

endmodule

// File: tb/tb_serial_tx_device.sv
// Self-checking bench for serial_tx_device (CLK_DIV=4). A queue-based model
// predicts the line waveform cycle by cycle, the bus read data and intr.
module tb_serial_tx_device;
  import serial_tx_pkg::*;

  localparam int unsigned CDIV = 4;
  localparam int unsigned DW   = 8;
  localparam logic [31:0] A_DATA = 32'hF0000010;
  localparam logic [31:0] A_CTRL = 32'hF0000110;
`ifdef SERIAL_TX_FIFO_EN
  localparam int unsigned CAP = 4;
`else
  localparam int unsigned CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [31:0] memAddr, dataBusIn, dataBusOut;
  logic        txd, intr;

  serial_tx_device #(.CLK_DIV(CDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .re        (re),
    .memAddr   (memAddr),
    .dataBusIn (dataBusIn),
    .dataBusOut(dataBusOut),
    .txd       (txd),
    .intr      (intr)
  );

  always #5 clk = ~clk;

  // Model: pending bytes, line levels still to come (head = current cycle).
  logic [7:0] holdQ[$];
  bit         lineQ[$];
  logic [7:0] mLast;
  bit         mOvr, mIe;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [31:0] ctrlExp();
    logic [31:0] c = '0;
    c[0] = (holdQ.size() < CAP);
    c[1] = (lineQ.size() != 0) || (holdQ.size() != 0);
    c[2] = mOvr;
`ifdef SERIAL_TX_FIFO_EN
    c[7:4] = 4'(holdQ.size());
`endif
    c[8] = mIe;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model across one clock edge with the given bus inputs.
  task automatic modelEdge(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit         wasReady, hadPending, lineEnding;
    logic [7:0] b;
    if (rst) begin
      holdQ.delete();
      lineQ.delete();
      mLast = '0;
      mOvr  = 1'b0;
      mIe   = 1'b0;
      return;
    end
    wasReady   = (holdQ.size() < CAP);
    hadPending = (holdQ.size() != 0);
    lineEnding = (lineQ.size() <= 1);
    if (lineQ.size() != 0) void'(lineQ.pop_front());
    if (hadPending && lineEnding) begin
      b = holdQ.pop_front();
      for (int k = 0; k < CDIV; k++) lineQ.push_back(1'b0);
      for (int i = 0; i < DW; i++)
        for (int k = 0; k < CDIV; k++) lineQ.push_back(b[i]);
      for (int k = 0; k < CDIV; k++) lineQ.push_back(1'b1);
    end
    if (w && a == A_DATA) begin
      if (wasReady) begin
        holdQ.push_back(d[7:0]);
        mLast = d[7:0];
      end else begin
        mOvr = 1'b1;
      end
    end
    if (w && a == A_CTRL) begin
      mIe = d[8];
      if (!d[2]) mOvr = 1'b0;
    end
  endtask

  // One bus cycle: drive, check read data, clock, check registered outputs.
  task automatic step(input bit rst, input bit w, input bit r,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] expRd;
    reset = rst; we = w; re = r; memAddr = a; dataBusIn = d;
    #1;
    expRd = '0;
    if (r && !w) begin
      if (a == A_DATA)      expRd = {24'h0, mLast};
      else if (a == A_CTRL) expRd = ctrlExp();
    end
    chk("dataBusOut", dataBusOut, expRd);
    @(posedge clk);
    modelEdge(rst, w, a, d);
    @(negedge clk);
    chk("txd", {31'h0, txd}, {31'h0, (lineQ.size() != 0) ? lineQ[0] : 1'b1});
    chk("intr", {31'h0, intr}, {31'h0, mIe && (holdQ.size() < CAP)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, A_CTRL, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b0, a, d);
  endtask

  initial begin
    int sel;
    reset = 1'b1; we = 1'b0; re = 1'b0; memAddr = '0; dataBusIn = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state and ctrl readback.
    step(1'b0, 1'b0, 1'b1, A_CTRL, '0);
    step(1'b0, 1'b0, 1'b1, A_DATA, '0);

    // Enable interrupt; single frame of 0x55.
    wr(A_CTRL, 32'h100);
    idle(2);
    wr(A_DATA, 32'h55);
    idle(frameLen(DW, CDIV) + 3);
    step(1'b0, 1'b0, 1'b1, A_DATA, '0);

    // 0x41: ready drops for a single cycle.
    wr(A_DATA, 32'h41);
    idle(frameLen(DW, CDIV) + 3);

    // Back-to-back frames 0xA5 then 0x3C once ready.
    wr(A_DATA, 32'hA5);
    idle(3);
    wr(A_DATA, 32'h3C);
    idle(2 * frameLen(DW, CDIV) + 4);

    // Write while not ready -> overrun; write 0 clears it.
    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    idle(2);
    wr(A_CTRL, 32'h104);
    idle(1);
    wr(A_CTRL, 32'h100);
    idle(frameLen(DW, CDIV));

    // Five rapid writes (fills FIFO when enabled, overruns otherwise).
    for (int i = 0; i < 5; i++) wr(A_DATA, 32'h60 + 32'(i));
    idle(5 * frameLen(DW, CDIV) + 6);
    wr(A_CTRL, 32'h000);

    // Reset mid-frame at frame cycle 15.
    wr(A_DATA, 32'hC3);
    idle(16);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(10);

    // we and re together act as a write with no read data.
    step(1'b0, 1'b1, 1'b1, A_CTRL, 32'h100);
    step(1'b0, 1'b1, 1'b1, A_DATA, 32'h9E);
    idle(frameLen(DW, CDIV) + 2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 5)       wr(A_DATA, $urandom());
      else if (sel < 8)  wr(A_CTRL, $urandom() & 32'h0000_0104 | 32'($urandom_range(0, 1)) << 8);
      else if (sel < 9)  step(1'b1, 1'b0, 1'b0, '0, '0);
      else if (sel < 14) step(1'b0, 1'b0, 1'b1, A_DATA, '0);
      else if (sel < 16) step(1'b0, 1'b1, 1'b1, A_DATA, $urandom());
      else if (sel < 19) step(1'b0, 1'b0, 1'b1, $urandom(), '0);
      else               step(1'b0, 1'b0, 1'b1, A_CTRL, '0);
    end
    idle(frameLen(DW, CDIV) * CAP + 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
